// File: rtl/rx_packet_ctrl.sv
// Receiver sequencer: programmable oversampling tick generator, 3-byte mouse packet
// assembler with alignment check, inter-byte timeout and a one-packet output holding register.
module rx_packet_ctrl #(
    parameter int DVSR_W       = 11,
    parameter int DEFAULT_DVSR = 651,
    parameter int TO_TICKS     = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dvsr_wr,
    input  logic [DVSR_W-1:0] dvsr_in,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [23:0]       pkt_data,
    output logic              sync_err,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int                TO_W     = $clog2(TO_TICKS + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_TICKS - 1);
    localparam logic [DVSR_W-1:0] DVSR_RST = DVSR_W'(DEFAULT_DVSR);

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    logic [DVSR_W-1:0] dvsr_r;
    logic [DVSR_W-1:0] tick_cnt_r;
    logic              s_tick_r;
    state_t            state_r;
    logic [7:0]        byte0_r;
    logic [7:0]        byte1_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              pkt_valid_r;
    logic [23:0]       pkt_data_r;
    logic              sync_err_r;
    logic              timeout_err_r;
    logic              overrun_err_r;

    // Terminal count for a divisor; 0 and 1 both mean a tick every cycle.
    function automatic logic [DVSR_W-1:0] tick_last(input logic [DVSR_W-1:0] d);
        if (d <= DVSR_W'(1)) begin
            tick_last = '0;
        end else begin
            tick_last = d - DVSR_W'(1);
        end
    endfunction

    // Tick generator; s_tick_r mirrors (counter == terminal) for the counter value being loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_r     <= DVSR_RST;
            tick_cnt_r <= '0;
            s_tick_r   <= 1'b0;
        end else if (dvsr_wr) begin
            dvsr_r     <= dvsr_in;
            tick_cnt_r <= '0;
            s_tick_r   <= (tick_last(dvsr_in) == '0);
        end else if (tick_cnt_r == tick_last(dvsr_r)) begin
            tick_cnt_r <= '0;
            s_tick_r   <= (tick_last(dvsr_r) == '0);
        end else begin
            tick_cnt_r <= tick_cnt_r + DVSR_W'(1);
            s_tick_r   <= ((tick_cnt_r + DVSR_W'(1)) == tick_last(dvsr_r));
        end
    end

    // Packet FSM, timeout counter, holding register and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= WAIT0;
            byte0_r       <= 8'h00;
            byte1_r       <= 8'h00;
            to_cnt_r      <= '0;
            pkt_valid_r   <= 1'b0;
            pkt_data_r    <= 24'h000000;
            sync_err_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            sync_err_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
            if (pkt_valid_r && pkt_ready) begin
                pkt_valid_r <= 1'b0;
            end else begin
                pkt_valid_r <= pkt_valid_r;
            end
            // A byte in the same cycle as an expiring timeout takes priority.
            if (rx_done_tick) begin
                to_cnt_r <= '0;
                case (state_r)
                    WAIT0: begin
                        if (rx_data[3]) begin
                            byte0_r <= rx_data;
                            state_r <= WAIT1;
                        end else begin
                            sync_err_r <= 1'b1;
                        end
                    end
                    WAIT1: begin
                        byte1_r <= rx_data;
                        state_r <= WAIT2;
                    end
                    WAIT2: begin
                        state_r <= WAIT0;
                        if (!pkt_valid_r || pkt_ready) begin
                            pkt_data_r  <= {rx_data, byte1_r, byte0_r};
                            pkt_valid_r <= 1'b1;
                        end else begin
                            overrun_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= WAIT0;
                    end
                endcase
            end else if (state_r == WAIT0) begin
                to_cnt_r <= '0;
            end else if (s_tick_r) begin
                if (to_cnt_r == TO_LAST) begin
                    timeout_err_r <= 1'b1;
                    state_r       <= WAIT0;
                    to_cnt_r      <= '0;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end
    end

    assign s_tick      = s_tick_r;
    assign pkt_valid   = pkt_valid_r;
    assign pkt_data    = pkt_data_r;
    assign sync_err    = sync_err_r;
    assign timeout_err = timeout_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Self-checking bench for rx_packet_ctrl: vector table of packets, expected-packet
// scoreboard popped on each handshake, and directed sequences for the multi-cycle cases.
module tb_rx_packet_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dvsr_wr = 1'b0;
    logic [10:0] dvsr_in = 11'd0;
    logic        s_tick;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [23:0] pkt_data;
    logic        sync_err;
    logic        timeout_err;
    logic        overrun_err;

    int n_cmp = 0;
    int n_fail = 0;
    int n_sync = 0;
    int n_to = 0;
    int n_ov = 0;
    logic [23:0] sb[$];

    typedef struct {
        logic        has_lead;
        logic [7:0]  lead;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp_pkt;
        int          exp_sync;
    } vec_t;
    vec_t vecs[4];

    rx_packet_ctrl #(.DVSR_W(11), .DEFAULT_DVSR(651), .TO_TICKS(480)) dut (
        .clk(clk), .reset(reset), .dvsr_wr(dvsr_wr), .dvsr_in(dvsr_in), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_data(pkt_data), .sync_err(sync_err),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transfers and error pulses are observed mid-cycle, away from the driving edge.
    always @(negedge clk) begin
        if (sync_err) n_sync++;
        if (timeout_err) n_to++;
        if (overrun_err) n_ov++;
        if (pkt_valid && pkt_ready) begin
            chk("xfer queued", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("xfer data", 32'(pkt_data), 32'(sb.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        pkt_ready = r;
    endtask

    task automatic measure_ticks(input int first_exp, input int period_exp, input string tag);
        int first_t = -1;
        int second_t = -1;
        for (int n = 1; (n <= first_exp + period_exp + 10) && (second_t < 0); n++) begin
            @(negedge clk);
            if (s_tick) begin
                if (first_t < 0) first_t = n;
                else second_t = n;
            end
        end
        chk({tag, " first tick"}, first_t, first_exp);
        chk({tag, " tick period"}, second_t - first_t, period_exp);
    endtask

    initial begin
        int s0, s1, s2;
        vecs[0] = '{1'b0, 8'h00, 8'h08, 8'h12, 8'hFE, 24'hFE1208, 0};
        vecs[1] = '{1'b1, 8'h00, 8'h09, 8'h01, 8'h02, 24'h020109, 1};
        vecs[2] = '{1'b1, 8'h77, 8'h0F, 8'hAA, 8'h55, 24'h55AA0F, 1};
        vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h80, 24'h8000FF, 0};

        // reset values and default tick rate
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst s_tick", 32'(s_tick), 32'd0);
        chk("rst pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst pkt_data", 32'(pkt_data), 32'd0);
        chk("rst errors", 32'({sync_err, timeout_err, overrun_err}), 32'd0);
        measure_ticks(651, 651, "default");

        // divisor reload
        @(posedge clk); #1;
        dvsr_wr = 1'b1;
        dvsr_in = 11'd4;
        @(posedge clk); #1;
        dvsr_wr = 1'b0;
        measure_ticks(4, 4, "dvsr4");

        // table of packets, consumer always ready
        set_ready(1'b1);
        for (int i = 0; i < 4; i++) begin
            s0 = n_sync;
            if (vecs[i].has_lead) send_byte(vecs[i].lead);
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            sb.push_back(vecs[i].exp_pkt);
            send_byte(vecs[i].b2);
            chk($sformatf("v%0d valid rise", i), 32'(pkt_valid), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("v%0d valid fall", i), 32'(pkt_valid), 32'd0);
            chk($sformatf("v%0d sync_err count", i), n_sync - s0, vecs[i].exp_sync);
        end

        // inter-byte timeout after a lone byte0, then a clean packet
        s0 = n_to;
        send_byte(8'h08);
        repeat (470 * 4) @(posedge clk);
        chk("timeout early", n_to - s0, 0);
        repeat (100 * 4) @(posedge clk);
        chk("timeout pulse", n_to - s0, 1);
        sb.push_back(24'h020118);
        send_byte(8'h18);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (3) @(posedge clk);
        chk("timeout single", n_to - s0, 1);

        // backpressure and overrun
        set_ready(1'b0);
        s0 = n_ov;
        sb.push_back(24'h020108);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
        chk("ovr held valid", 32'(pkt_valid), 32'd1);
        chk("ovr held data", 32'(pkt_data), 32'h020108);
        send_byte(8'h0A); send_byte(8'h03); send_byte(8'h04);
        repeat (2) @(posedge clk); #1;
        chk("ovr pulse", n_ov - s0, 1);
        chk("ovr data kept", 32'(pkt_data), 32'h020108);
        set_ready(1'b1);
        repeat (2) @(posedge clk); #1;
        chk("ovr drained", 32'(pkt_valid), 32'd0);

        // byte2 lands in the same cycle as a transfer
        set_ready(1'b0);
        s0 = n_ov;
        sb.push_back(24'h221108);
        send_byte(8'h08); send_byte(8'h11); send_byte(8'h22);
        sb.push_back(24'h55440C);
        send_byte(8'h0C); send_byte(8'h44);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        rx_data = 8'h55;
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        pkt_ready = 1'b0;
        chk("simul valid", 32'(pkt_valid), 32'd1);
        chk("simul data", 32'(pkt_data), 32'h55440C);
        repeat (2) @(posedge clk);
        chk("simul no overrun", n_ov - s0, 0);
        set_ready(1'b1);
        repeat (2) @(posedge clk); #1;
        chk("simul drained", 32'(pkt_valid), 32'd0);

        // reset with a held packet and a partial one in flight
        set_ready(1'b0);
        send_byte(8'h08); send_byte(8'h05); send_byte(8'h06);
        send_byte(8'h08); send_byte(8'h01);
        s0 = n_sync; s1 = n_to; s2 = n_ov;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("mid rst pkt_valid", 32'(pkt_valid), 32'd0);
        chk("mid rst pkt_data", 32'(pkt_data), 32'd0);
        chk("mid rst s_tick", 32'(s_tick), 32'd0);
        chk("mid rst errors", 32'({sync_err, timeout_err, overrun_err}), 32'd0);
        set_ready(1'b1);
        sb.push_back(24'h3B2A18);
        send_byte(8'h18); send_byte(8'h2A); send_byte(8'h3B);
        repeat (3) @(posedge clk);
        chk("mid rst no errors", (n_sync - s0) + (n_to - s1) + (n_ov - s2), 0);
        chk("scoreboard empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
